// File: rtl/chacha_ctrl_if.sv
// rtl/chacha_ctrl_if.sv - host/datapath signal bundle for the ChaCha sequencer
//
// Purpose:
//   Groups the host strobes and the datapath control outputs of chacha_ctrl
//   so the sequencer, the host wrapper and the datapath share one bundle.
//
// Signals:
//   wr_key, wr_nnc, wr_ctr  host -> ctrl  load-start strobes (key / nonce / counter)
//   rd_blk                  host -> ctrl  consume one output byte this cycle
//   ld_en, ld_sel, ld_addr  ctrl -> dp    byte load strobe, target, byte index
//   rnd_en, rnd_diag        ctrl -> dp    advance one round cycle, column/diagonal
//   add_en                  ctrl -> dp    final feed-forward add
//   rd_addr                 ctrl -> dp    output byte index
//   ctr_inc                 ctrl -> dp    block counter increment pulse
//   blk_ready, busy         ctrl -> host  status
//
// Modports:
//   master  host side (drives strobes, observes controls/status)
//   slave   the sequencer itself
interface chacha_ctrl_if;
  logic       wr_key;
  logic       wr_nnc;
  logic       wr_ctr;
  logic       rd_blk;
  logic       ld_en;
  logic [1:0] ld_sel;
  logic [5:0] ld_addr;
  logic       rnd_en;
  logic       rnd_diag;
  logic       add_en;
  logic [5:0] rd_addr;
  logic       ctr_inc;
  logic       blk_ready;
  logic       busy;

  modport master (
    output wr_key, wr_nnc, wr_ctr, rd_blk,
    input  ld_en, ld_sel, ld_addr, rnd_en, rnd_diag, add_en,
    input  rd_addr, ctr_inc, blk_ready, busy
  );

  modport slave (
    input  wr_key, wr_nnc, wr_ctr, rd_blk,
    output ld_en, ld_sel, ld_addr, rnd_en, rnd_diag, add_en,
    output rd_addr, ctr_inc, blk_ready, busy
  );
endinterface

// File: rtl/chacha_ctrl.sv
// rtl/chacha_ctrl.sv - ChaCha block sequencer (load, rounds, final add, readout)
//
// Purpose:
//   Orders the ChaCha datapath through one block at a time:
//     key / nonce / counter byte loads -> ROUNDS*QR_CYCLES round cycles
//     (column and diagonal passes alternate, column first) -> one
//     feed-forward add -> 64-byte readout. A complete readout pulses the
//     counter increment and restarts the rounds for the next block.
//   Any write strobe during readout abandons the block and starts a load.
//
// Parameters:
//   ROUNDS     total rounds, even and >= 2
//   QR_CYCLES  datapath cycles per round, >= 1
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    chacha_ctrl_if.slave (host strobes in, datapath controls out)
//
// Timing:
//   Every output except ctr_inc is a function of registered state only.
//   ctr_inc is high in the cycle that consumes byte 63, so the datapath
//   counter has advanced before the first round cycle of the next block.
module chacha_ctrl #(
  parameter int ROUNDS    = 20,
  parameter int QR_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  chacha_ctrl_if.slave  bus
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int QW = (QR_CYCLES > 1) ? $clog2(QR_CYCLES) : 1;

  localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS - 1);
  localparam logic [QW-1:0] QR_LAST  = QW'(QR_CYCLES - 1);

  localparam logic [1:0] SEL_KEY = 2'd0;
  localparam logic [1:0] SEL_NNC = 2'd1;
  localparam logic [1:0] SEL_CTR = 2'd2;

  localparam logic [5:0] KEY_LAST = 6'd31;
  localparam logic [5:0] NNC_LAST = 6'd11;
  localparam logic [5:0] CTR_LAST = 6'd3;
  localparam logic [5:0] RD_LAST  = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_READY,
    S_READ
  } state_t;

  state_t        state_q,   state_d;
  logic [1:0]    sel_q,     sel_d;
  logic [5:0]    ld_cnt_q,  ld_cnt_d;
  logic [RW-1:0] rnd_cnt_q, rnd_cnt_d;
  logic [QW-1:0] qr_cnt_q,  qr_cnt_d;
  logic [5:0]    rd_addr_q, rd_addr_d;
  logic          key_vld_q, key_vld_d;
  logic          nnc_vld_q, nnc_vld_d;

  logic          any_wr;
  logic          can_accept;
  logic          readable;
  logic [5:0]    ld_last_addr;
  logic [1:0]    wr_sel;

  assign any_wr     = bus.wr_key | bus.wr_nnc | bus.wr_ctr;
  assign readable   = (state_q == S_READY) || (state_q == S_READ);
  assign can_accept = (state_q == S_IDLE) || readable;

  // Simultaneous strobes resolve key > nonce > counter.
  assign wr_sel = bus.wr_key ? SEL_KEY :
                  bus.wr_nnc ? SEL_NNC : SEL_CTR;

  always_comb begin
    unique case (sel_q)
      SEL_KEY: ld_last_addr = KEY_LAST;
      SEL_NNC: ld_last_addr = NNC_LAST;
      default: ld_last_addr = CTR_LAST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= SEL_KEY;
      ld_cnt_q  <= '0;
      rnd_cnt_q <= '0;
      qr_cnt_q  <= '0;
      rd_addr_q <= '0;
      key_vld_q <= 1'b0;
      nnc_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ld_cnt_q  <= ld_cnt_d;
      rnd_cnt_q <= rnd_cnt_d;
      qr_cnt_q  <= qr_cnt_d;
      rd_addr_q <= rd_addr_d;
      key_vld_q <= key_vld_d;
      nnc_vld_q <= nnc_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ld_cnt_d  = ld_cnt_q;
    rnd_cnt_d = rnd_cnt_q;
    qr_cnt_d  = qr_cnt_q;
    rd_addr_d = rd_addr_q;
    key_vld_d = key_vld_q;
    nnc_vld_d = nnc_vld_q;

    bus.ld_en     = 1'b0;
    bus.ld_sel    = 2'd0;
    bus.ld_addr   = 6'd0;
    bus.rnd_en    = 1'b0;
    bus.rnd_diag  = 1'b0;
    bus.add_en    = 1'b0;
    bus.rd_addr   = rd_addr_q;
    bus.ctr_inc   = 1'b0;
    bus.blk_ready = readable;
    bus.busy      = 1'b0;

    unique case (state_q)
      S_IDLE, S_READY, S_READ: begin
        if (can_accept && any_wr) begin
          // A strobe during readout abandons the current block.
          state_d   = S_LOAD;
          sel_d     = wr_sel;
          ld_cnt_d  = '0;
          rd_addr_d = '0;
        end else if (readable && bus.rd_blk) begin
          if (rd_addr_q == RD_LAST) begin
            bus.ctr_inc = 1'b1;
            rd_addr_d   = '0;
            rnd_cnt_d   = '0;
            qr_cnt_d    = '0;
            state_d     = S_ROUND;
          end else begin
            rd_addr_d = rd_addr_q + 6'd1;
            state_d   = S_READ;
          end
        end
      end

      S_LOAD: begin
        bus.ld_en   = 1'b1;
        bus.ld_sel  = sel_q;
        bus.ld_addr = ld_cnt_q;
        if (ld_cnt_q == ld_last_addr) begin
          ld_cnt_d = '0;
          if (sel_q == SEL_KEY) key_vld_d = 1'b1;
          if (sel_q == SEL_NNC) nnc_vld_d = 1'b1;
          // Only a counter load launches a block, and only once the rest
          // of the state is present; the valid flags cannot change while
          // the counter itself is loading.
          if ((sel_q == SEL_CTR) && key_vld_q && nnc_vld_q) begin
            rnd_cnt_d = '0;
            qr_cnt_d  = '0;
            state_d   = S_ROUND;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ld_cnt_d = ld_cnt_q + 6'd1;
        end
      end

      S_ROUND: begin
        bus.rnd_en   = 1'b1;
        bus.rnd_diag = rnd_cnt_q[0];
        bus.busy     = 1'b1;
        if (qr_cnt_q == QR_LAST) begin
          qr_cnt_d = '0;
          if (rnd_cnt_q == RND_LAST) begin
            rnd_cnt_d = '0;
            state_d   = S_FINAL;
          end else begin
            rnd_cnt_d = rnd_cnt_q + 1'b1;
          end
        end else begin
          qr_cnt_d = qr_cnt_q + 1'b1;
        end
      end

      S_FINAL: begin
        bus.add_en = 1'b1;
        bus.busy   = 1'b1;
        state_d    = S_READY;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_chacha_ctrl.sv
// tb/tb_chacha_ctrl.sv - self-checking bench for chacha_ctrl
module tb_chacha_ctrl;

  localparam int ROUNDS = 20;
  localparam int QR     = 4;
  localparam int RQ     = ROUNDS * QR;

  typedef struct packed {
    logic       ld_en;
    logic [1:0] ld_sel;
    logic [5:0] ld_addr;
    logic       rnd_en;
    logic       rnd_diag;
    logic       add_en;
    logic [5:0] rd_addr;
    logic       ctr_inc;
    logic       blk_ready;
    logic       busy;
  } outs_t;

  typedef struct {
    bit         wk;
    bit         wn;
    bit         wc;
    int         exp_sel;
    int         exp_len;
    int         exp_rnd;
    int         exp_lat;
    bit         exp_blk;
    logic [7:0] exp_diag;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  chacha_ctrl_if bus ();

  chacha_ctrl #(.ROUNDS(ROUNDS), .QR_CYCLES(QR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: busy/load phases are a queue of expected output
  // records built from the schedule rules; idle and readout are tracked
  // by a ready flag and the next byte to be read.
  outs_t sched[$];
  bit    m_key, m_nnc, m_ready;
  int    m_addr;

  function automatic void model_reset();
    sched.delete();
    m_key = 0; m_nnc = 0; m_ready = 0; m_addr = 0;
  endfunction

  function automatic void push_load(input int sel);
    int    n;
    outs_t r;
    n = (sel == 0) ? 32 : (sel == 1) ? 12 : 4;
    for (int i = 0; i < n; i++) begin
      r = '0; r.ld_en = 1'b1; r.ld_sel = 2'(sel); r.ld_addr = 6'(i);
      sched.push_back(r);
    end
  endfunction

  function automatic void push_block();
    outs_t r;
    for (int c = 0; c < RQ; c++) begin
      r = '0; r.rnd_en = 1'b1; r.rnd_diag = ((c / QR) % 2) == 1; r.busy = 1'b1;
      sched.push_back(r);
    end
    r = '0; r.add_en = 1'b1; r.busy = 1'b1;
    sched.push_back(r);
  endfunction

  function automatic outs_t model_expect(input bit wk, input bit wn, input bit wc, input bit rd);
    outs_t e;
    e = '0;
    if (sched.size() > 0) e = sched[0];
    else if (m_ready) begin
      e.blk_ready = 1'b1;
      e.rd_addr   = 6'(m_addr);
      e.ctr_inc   = rd && (m_addr == 63) && !(wk || wn || wc);
    end
    return e;
  endfunction

  function automatic void model_update(input bit wk, input bit wn, input bit wc, input bit rd);
    outs_t r;
    int    sel;
    if (sched.size() > 0) begin
      r = sched.pop_front();
      if (r.add_en) begin m_ready = 1; m_addr = 0; end
    end else if (wk || wn || wc) begin
      sel = wk ? 0 : wn ? 1 : 2;
      m_ready = 0; m_addr = 0;
      push_load(sel);
      if (sel == 0) m_key = 1;
      if (sel == 1) m_nnc = 1;
      if (sel == 2 && m_key && m_nnc) push_block();
    end else if (m_ready && rd) begin
      if (m_addr == 63) begin m_ready = 0; m_addr = 0; push_block(); end
      else m_addr++;
    end
  endfunction

  // Observations of actual DUT behaviour for the directed checks.
  int         cyc = 0;
  int         obs_ld_cnt, obs_last_sel, obs_last_addr, t_last_ld;
  int         obs_rnd_cnt, obs_inc_cnt, t_inc, t_blk;
  int         obs_rd_next, obs_rd_bad;
  logic [7:0] obs_diag;
  bit         prev_blk = 0;
  outs_t      last_act;

  function automatic void clear_obs();
    obs_ld_cnt = 0; obs_last_sel = -1; obs_last_addr = -1; t_last_ld = -1;
    obs_rnd_cnt = 0; obs_inc_cnt = 0; t_inc = -1; t_blk = -1;
    obs_rd_next = 0; obs_rd_bad = 0; obs_diag = '0;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.ld_en = bus.ld_en; o.ld_sel = bus.ld_sel; o.ld_addr = bus.ld_addr;
    o.rnd_en = bus.rnd_en; o.rnd_diag = bus.rnd_diag; o.add_en = bus.add_en;
    o.rd_addr = bus.rd_addr; o.ctr_inc = bus.ctr_inc;
    o.blk_ready = bus.blk_ready; o.busy = bus.busy;
    return o;
  endfunction

  task automatic step(input bit wk, input bit wn, input bit wc, input bit rd);
    outs_t act, ex;
    @(negedge clk);
    bus.wr_key = wk; bus.wr_nnc = wn; bus.wr_ctr = wc; bus.rd_blk = rd;
    #1;
    act = sample();
    ex  = model_expect(wk, wn, wc, rd);
    check("cycle_outputs", 64'(act), 64'(ex));
    if (act.ld_en) begin
      obs_ld_cnt++; obs_last_sel = act.ld_sel; obs_last_addr = act.ld_addr; t_last_ld = cyc;
    end
    if (act.rnd_en) begin
      if (obs_rnd_cnt < 8) obs_diag[obs_rnd_cnt] = act.rnd_diag;
      obs_rnd_cnt++;
    end
    if (act.ctr_inc) begin obs_inc_cnt++; t_inc = cyc; end
    if (act.blk_ready && !prev_blk && t_blk < 0) t_blk = cyc;
    if (rd && act.blk_ready && !(wk || wn || wc)) begin
      if (act.rd_addr != 6'(obs_rd_next % 64)) obs_rd_bad++;
      obs_rd_next++;
    end
    prev_blk = act.blk_ready;
    last_act = act;
    model_update(wk, wn, wc, rd);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  vec_t vecs[4];

  initial begin
    int lat;

    vecs[0] = '{wk:0, wn:0, wc:1, exp_sel:2, exp_len:4,  exp_rnd:0,  exp_lat:-1, exp_blk:0, exp_diag:8'h00};
    vecs[1] = '{wk:1, wn:0, wc:1, exp_sel:0, exp_len:32, exp_rnd:0,  exp_lat:-1, exp_blk:0, exp_diag:8'h00};
    vecs[2] = '{wk:0, wn:1, wc:0, exp_sel:1, exp_len:12, exp_rnd:0,  exp_lat:-1, exp_blk:0, exp_diag:8'h00};
    vecs[3] = '{wk:0, wn:0, wc:1, exp_sel:2, exp_len:4,  exp_rnd:RQ, exp_lat:RQ + 2, exp_blk:1, exp_diag:8'hF0};

    rst_n = 1'b0;
    bus.wr_key = 0; bus.wr_nnc = 0; bus.wr_ctr = 0; bus.rd_blk = 0;
    model_reset();
    clear_obs();
    #12;
    check("reset_outputs", 64'(sample()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load ordering, guard, priority and block latency, applied in sequence.
    foreach (vecs[i]) begin
      clear_obs();
      step(vecs[i].wk, vecs[i].wn, vecs[i].wc, 0);
      idle(120);
      lat = (t_blk >= 0 && t_last_ld >= 0) ? t_blk - t_last_ld : -1;
      check($sformatf("vec%0d_ld_count", i), obs_ld_cnt, vecs[i].exp_len);
      check($sformatf("vec%0d_ld_sel", i), obs_last_sel, vecs[i].exp_sel);
      check($sformatf("vec%0d_ld_last_addr", i), obs_last_addr, vecs[i].exp_len - 1);
      check($sformatf("vec%0d_rnd_count", i), obs_rnd_cnt, vecs[i].exp_rnd);
      check($sformatf("vec%0d_blk_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_blk_ready", i), last_act.blk_ready, vecs[i].exp_blk);
      check($sformatf("vec%0d_diag_pattern", i), obs_diag, vecs[i].exp_diag);
    end

    // Full readout with a gap, then auto-restart of the next block.
    clear_obs();
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1);
    idle(5);
    check("gap_hold_rd_addr", last_act.rd_addr, 30);
    check("gap_blk_ready", last_act.blk_ready, 1);
    for (int i = 0; i < 34; i++) step(0, 0, 0, 1);
    check("readout_ctr_inc_count", obs_inc_cnt, 1);
    check("readout_bytes", obs_rd_next, 64);
    check("readout_order_errors", obs_rd_bad, 0);
    step(0, 0, 0, 0);
    check("after_readout_blk_ready", last_act.blk_ready, 0);
    check("after_readout_rd_addr", last_act.rd_addr, 0);
    idle(90);
    lat = (t_blk >= 0 && t_inc >= 0) ? t_blk - t_inc : -1;
    check("next_block_latency", lat, RQ + 2);
    check("next_block_rnd_count", obs_rnd_cnt, RQ);
    check("next_block_ctr_inc_count", obs_inc_cnt, 1);

    // Abort of a readout at byte 20 by a nonce write.
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    clear_obs();
    step(0, 1, 0, 1);
    check("abort_rd_addr", last_act.rd_addr, 20);
    idle(20);
    check("abort_ld_count", obs_ld_cnt, 12);
    check("abort_ld_sel", obs_last_sel, 1);
    check("abort_ctr_inc", obs_inc_cnt, 0);
    check("abort_blk_ready", last_act.blk_ready, 0);
    check("abort_rd_addr_zero", last_act.rd_addr, 0);

    // Key write during rounds is ignored.
    step(0, 0, 1, 0);
    idle(10);
    clear_obs();
    step(1, 0, 0, 0);
    idle(5);
    check("round_wr_key_ld_count", obs_ld_cnt, 0);
    check("round_busy", last_act.busy, 1);

    // Asynchronous reset in the middle of the rounds.
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'(sample()), 64'd0);
    model_reset();
    prev_blk = 0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    step(0, 0, 1, 0);
    idle(20);
    check("post_reset_ctr_ld_count", obs_ld_cnt, 4);
    check("post_reset_no_rounds", obs_rnd_cnt, 0);
    check("post_reset_blk_ready", last_act.blk_ready, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 5000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 299) == 0,
           $urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
